// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  fft_pkg : shared FFT datapath widths and saturation-limit helpers
//  Rev 1.0
// ============================================================================
package fft_pkg;

    localparam int DEF_DATA_W  = 24;
    localparam int DEF_TW_W    = 16;
    localparam int DEF_TW_FRAC = 13;

    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_sat.sv
`default_nettype none
// ============================================================================
//  round_sat : round-half-up by FRAC bits, then saturate to OUT_W signed
//  Rev 1.0
// ============================================================================
module round_sat
    import fft_pkg::*;
#(
    parameter int IN_W  = 41,
    parameter int OUT_W = 24,
    parameter int FRAC  = 13
) (
    input  logic signed [IN_W-1:0]  x_i,
    output logic signed [OUT_W-1:0] y_o,
    output logic                    sat_o
);

    localparam logic signed [IN_W:0] c_half =
        {{(IN_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [63:0] c_max = sat_max(OUT_W);
    localparam logic signed [63:0] c_min = sat_min(OUT_W);

    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shift;
    logic signed [63:0]   w_wide;

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    assign w_sum   = (IN_W+1)'(x_i) + c_half;
    assign w_shift = w_sum >>> FRAC;
    assign w_wide  = 64'(w_shift);

    always_comb begin
        sat_o = 1'b0;
        y_o   = w_shift[OUT_W-1:0];
        if (w_wide > c_max) begin
            sat_o = 1'b1;
            y_o   = c_max[OUT_W-1:0];
        end else if (w_wide < c_min) begin
            sat_o = 1'b1;
            y_o   = c_min[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cplx_twiddle_mult.sv
`default_nettype none
// ============================================================================
//  cplx_twiddle_mult : 3-stage complex data x twiddle multiplier, round/sat
//  Rev 1.0
// ============================================================================
module cplx_twiddle_mult
    import fft_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic                     conj,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] p_re,
    output logic signed [DATA_W-1:0] p_im,
    output logic                     ovf
);

    localparam int P_W = DATA_W + TW_W;
    localparam int S_W = P_W + 1;

    logic                     s1_valid_q, s1_conj_q;
    logic signed [P_W-1:0]    rr_q, ii_q, ri_q, ir_q;
    logic signed [P_W-1:0]    rr_d, ii_d, ri_d, ir_d;
    logic                     s2_valid_q;
    logic signed [S_W-1:0]    re_q, im_q, re_d, im_d;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] p_re_q, p_im_q, p_re_d, p_im_d;
    logic                     sat_re, sat_im;
    logic                     ovf_q, ovf_d;

    assign rr_d = P_W'(a_re) * P_W'(w_re);
    assign ii_d = P_W'(a_im) * P_W'(w_im);
    assign ri_d = P_W'(a_re) * P_W'(w_im);
    assign ir_d = P_W'(a_im) * P_W'(w_re);

    // Conjugating the twiddle flips the sign of every w_im product term.
    always_comb begin
        if (s1_conj_q) begin
            re_d = S_W'(rr_q) + S_W'(ii_q);
            im_d = S_W'(ir_q) - S_W'(ri_q);
        end else begin
            re_d = S_W'(rr_q) - S_W'(ii_q);
            im_d = S_W'(ri_q) + S_W'(ir_q);
        end
    end

    round_sat #(.IN_W(S_W), .OUT_W(DATA_W), .FRAC(TW_FRAC)) u_rs_re (
        .x_i   (re_q),
        .y_o   (p_re_d),
        .sat_o (sat_re)
    );

    round_sat #(.IN_W(S_W), .OUT_W(DATA_W), .FRAC(TW_FRAC)) u_rs_im (
        .x_i   (im_q),
        .y_o   (p_im_d),
        .sat_o (sat_im)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_conj_q   <= 1'b0;
            rr_q        <= '0;
            ii_q        <= '0;
            ri_q        <= '0;
            ir_q        <= '0;
            s2_valid_q  <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s1_conj_q   <= conj;
            rr_q        <= rr_d;
            ii_q        <= ii_d;
            ri_q        <= ri_d;
            ir_q        <= ir_d;
            s2_valid_q  <= s1_valid_q;
            re_q        <= re_d;
            im_q        <= im_d;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                p_re_q <= p_re_d;
                p_im_q <= p_im_d;
            end
        end
    end

    // Saturation takes priority so a clear cannot swallow a same-cycle event.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (en && s2_valid_q && (sat_re || sat_im)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p_re      = p_re_q;
    assign p_im      = p_im_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cplx_twiddle_mult.sv
`default_nettype none
// ============================================================================
//  tb_cplx_twiddle_mult : directed-vector bench for cplx_twiddle_mult
//  Rev 1.0
// ============================================================================
module tb_cplx_twiddle_mult;

    localparam int DW = 24;
    localparam int TW = 16;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 in_valid;
    logic                 conj;
    logic signed [DW-1:0] a_re, a_im;
    logic signed [TW-1:0] w_re, w_im;
    logic                 ovf_clr;
    logic                 out_valid;
    logic signed [DW-1:0] p_re, p_im;
    logic                 ovf;

    int checks   = 0;
    int failures = 0;

    cplx_twiddle_mult #(.DATA_W(DW), .TW_W(TW), .TW_FRAC(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .conj      (conj),
        .a_re      (a_re),
        .a_im      (a_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .p_re      (p_re),
        .p_im      (p_im),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic c, input int are, input int aim,
                         input int wre, input int wim);
        in_valid = v;
        conj     = c;
        a_re     = DW'(are);
        a_im     = DW'(aim);
        w_re     = TW'(wre);
        w_im     = TW'(wim);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b0;
        en      = 1'b1;
        ovf_clr = 1'b0;
        idle();
        #3;
        check("rst_valid", int'(out_valid), 0);
        check("rst_p_re",  int'(p_re), 0);
        check("rst_p_im",  int'(p_im), 0);
        check("rst_ovf",   int'(ovf), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Unity twiddle: latency and single-cycle pulse
        drive(1'b1, 1'b0, 1000, 0, 8192, 0);
        tick();
        idle();
        tick();
        check("lat_early_valid", int'(out_valid), 0);
        tick();
        check("unity_valid", int'(out_valid), 1);
        check("unity_re",    int'(p_re), 1000);
        check("unity_im",    int'(p_im), 0);
        check("unity_ovf",   int'(ovf), 0);
        tick();
        check("unity_pulse_end", int'(out_valid), 0);

        // j twiddle, normal then conjugate, back to back
        drive(1'b1, 1'b0, 1000, 2000, 0, 8192);
        tick();
        drive(1'b1, 1'b1, 1000, 2000, 0, 8192);
        tick();
        idle();
        tick();
        check("j_valid", int'(out_valid), 1);
        check("j_re",    int'(p_re), -2000);
        check("j_im",    int'(p_im), 1000);
        tick();
        check("jconj_valid", int'(out_valid), 1);
        check("jconj_re",    int'(p_re), 2000);
        check("jconj_im",    int'(p_im), -1000);
        tick();
        check("j_pulse_end", int'(out_valid), 0);

        // Round half toward +inf
        drive(1'b1, 1'b0, 3, 0, 4096, 0);
        tick();
        drive(1'b1, 1'b0, -3, 0, 4096, 0);
        tick();
        idle();
        tick();
        check("round_pos", int'(p_re), 2);
        tick();
        check("round_neg", int'(p_re), -1);
        check("round_ovf", int'(ovf), 0);

        // Positive saturation, sticky flag, clear
        drive(1'b1, 1'b0, 8388607, 8388607, 8192, -8192);
        tick();
        idle();
        tick();
        tick();
        check("satp_valid", int'(out_valid), 1);
        check("satp_re",    int'(p_re), 8388607);
        check("satp_im",    int'(p_im), 0);
        check("satp_ovf",   int'(ovf), 1);
        tick();
        tick();
        check("ovf_held", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);

        // Negative saturation; clear while disabled
        drive(1'b1, 1'b0, 8388607, 0, -16384, 0);
        tick();
        idle();
        tick();
        tick();
        check("satn_re",  int'(p_re), -8388608);
        check("satn_ovf", int'(ovf), 1);
        en      = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        en      = 1'b1;
        check("clr_while_frozen", int'(ovf), 0);

        // Set wins over a simultaneous clear
        drive(1'b1, 1'b0, 8388607, 0, -16384, 0);
        tick();
        idle();
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("set_wins", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("set_wins_clr", int'(ovf), 0);

        // Saturating operands in an invalid slot leave ovf alone
        drive(1'b0, 1'b0, 8388607, 8388607, 8192, -8192);
        tick();
        tick();
        tick();
        idle();
        check("invalid_ovf",   int'(ovf), 0);
        check("invalid_valid", int'(out_valid), 0);

        // Freeze with two results in flight
        drive(1'b1, 1'b0, 1000, 0, 8192, 0);
        tick();
        drive(1'b1, 1'b0, 3, 0, 4096, 0);
        tick();
        en = 1'b0;
        drive(1'b1, 1'b0, 500, 0, 8192, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("frozen_valid", int'(out_valid), 0);
        end
        check("frozen_p_re", int'(p_re), -8388608);
        idle();
        en = 1'b1;
        tick();
        check("resume1_valid", int'(out_valid), 1);
        check("resume1_re",    int'(p_re), 1000);
        tick();
        check("resume2_valid", int'(out_valid), 1);
        check("resume2_re",    int'(p_re), 2);
        tick();
        check("resume_no_dup", int'(out_valid), 0);

        // Asynchronous reset with results in flight
        drive(1'b1, 1'b0, 8388607, 8388607, 8192, -8192);
        tick();
        drive(1'b1, 1'b0, 1000, 0, 8192, 0);
        tick();
        drive(1'b1, 1'b0, 3, 0, 4096, 0);
        tick();
        drive(1'b1, 1'b0, -3, 0, 4096, 0);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_ovf",   int'(ovf), 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_p_re",  int'(p_re), 0);
        check("async_p_im",  int'(p_im), 0);
        check("async_ovf",   int'(ovf), 0);
        idle();
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_stale", int'(out_valid), 0);
        end
        drive(1'b1, 1'b0, 1000, 0, 8192, 0);
        tick();
        idle();
        tick();
        tick();
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_re",    int'(p_re), 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
